branch_ctrl: RTL



---
 rtl/branch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl: branch resolution and prediction controller for the RV32I EX
// stage. It decodes funct3 for the comparator, turns the eq/lt flags into a
// taken decision, detects mispredicts, and drives the PC redirect/flush. It
// also owns the branch history/target table that IF reads every cycle, and
// the resolved-branch and mispredict performance counters.
//
// Build option: define BRANCH_CTRL_PREDICT_EN to include the prediction
// table. Without it, the controller behaves as a static not-taken predictor.
// ---------------------------------------------------------------------------
module branch_ctrl #(
  parameter int BHT_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  input  logic        i_stall,
  output logic        o_br_un,
  input  logic        i_br_eq,
  input  logic        i_br_lt,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  input  logic        i_cnt_clr,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mis_cnt
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic        cond_taken;
  logic        br_legal;
  logic        taken;
  logic        resolve;
  logic        mispredict;
  logic [31:0] next_pc;
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  // Only bits [IDX_W+1:2] of the fetch PC index the table.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_if_pc};

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
  assign o_br_un = i_ex_funct3[1];

  // Decode the branch condition from funct3 and the comparator flags.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cond_taken = 1'b0;
    case (i_ex_funct3)
      3'b000:         cond_taken = i_br_eq;
      3'b001:         cond_taken = ~i_br_eq;
      3'b100, 3'b110: cond_taken = i_br_lt;
      3'b101, 3'b111: cond_taken = ~i_br_lt;
      default:        cond_taken = 1'b0;
    endcase
  end

  // funct3 010/011 are not branch encodings; they never resolve.
  assign br_legal = (i_ex_funct3[2:1] != 2'b01);

  // A jump wins when both is_br and is_jmp are set. Reset gates resolve so
  // nothing redirects or updates while the core is held in reset.
  assign taken   = i_ex_is_jmp | (i_ex_is_br & cond_taken);
  assign resolve = i_rst_n & i_ex_valid & ~i_stall &
                   (i_ex_is_jmp | (i_ex_is_br & br_legal));
  assign next_pc = taken ? i_ex_target : (i_ex_pc + 32'd4);

  assign o_redirect    = mispredict;
  assign o_redirect_pc = mispredict ? next_pc : 32'd0;

`ifdef BRANCH_CTRL_PREDICT_EN

  logic             bht_valid_q [BHT_DEPTH];
  logic [1:0]       bht_ctr_q   [BHT_DEPTH];
  logic [31:0]      bht_tgt_q   [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ctr_base;
  logic [1:0]       ctr_next;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];

  // IF lookup: reads the registered table, so a same-cycle update is not seen.
  assign o_pred_taken  = bht_valid_q[if_idx] & bht_ctr_q[if_idx][1];
  assign o_pred_target = o_pred_taken ? bht_tgt_q[if_idx] : 32'd0;

  assign mispredict = resolve &
                      ((taken != i_ex_pred_taken) |
                       (taken & i_ex_pred_taken & (i_ex_target != i_ex_pred_target)));

  // Next counter value for the entry being resolved; fresh entries start weak not-taken.
  always_comb begin
    ctr_base = bht_valid_q[ex_idx] ? bht_ctr_q[ex_idx] : 2'b01;
    ctr_next = ctr_base;
    if (i_ex_is_jmp) begin
      ctr_next = 2'b11;
    end else if (taken) begin
      if (ctr_base != 2'b11) ctr_next = ctr_base + 2'd1;
    end else begin
      if (ctr_base != 2'b00) ctr_next = ctr_base - 2'd1;
    end
  end

  // Table write on resolve.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the table is small and its reset contents are architecturally
      // visible (valid=0, ctr=01), so every entry is reset explicitly.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_valid_q[i] <= 1'b0;
        bht_ctr_q[i]   <= 2'b01;
        bht_tgt_q[i]   <= 32'd0;
      end
    end else if (resolve) begin
      bht_valid_q[ex_idx] <= 1'b1;
      bht_ctr_q[ex_idx]   <= ctr_next;
      if (taken) bht_tgt_q[ex_idx] <= i_ex_target;
    end
  end

`else

  // No table: static not-taken, so every taken resolve is a mispredict.
  logic unused_pred;
  assign unused_pred = &{1'b0, i_ex_pred_taken, i_ex_pred_target};

  assign o_pred_taken  = 1'b0;
  assign o_pred_target = 32'd0;
  assign mispredict    = resolve & taken;

`endif

  // Performance counters; clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else if (i_cnt_clr) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else if (resolve) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;

endmodule
